// File: rtl/twiddle_load_sequencer_if.sv
// Bus between the twiddle preload sequencer,
// its controller, the twiddle ROM and the register bank.
interface twiddle_load_sequencer_if #(
  parameter int AW = 7,
  parameter int DW = 16
) ();

  logic          start;
  logic          abort;
  logic [AW:0]   addr_a;
  logic [AW:0]   addr_b;
  logic [DW-1:0] rom_q_a;
  logic [DW-1:0] rom_q_b;
  logic          wr_en;
  logic [AW-1:0] wr_addr_a;
  logic [AW-1:0] wr_addr_b;
  logic [DW-1:0] wr_data_a;
  logic [DW-1:0] wr_data_b;
  logic          busy;
  logic          done;

  modport slave (
    input  start,
    input  abort,
    input  rom_q_a,
    input  rom_q_b,
    output addr_a,
    output addr_b,
    output wr_en,
    output wr_addr_a,
    output wr_addr_b,
    output wr_data_a,
    output wr_data_b,
    output busy,
    output done
  );

  modport master (
    output start,
    output abort,
    output rom_q_a,
    output rom_q_b,
    input  addr_a,
    input  addr_b,
    input  wr_en,
    input  wr_addr_a,
    input  wr_addr_b,
    input  wr_data_a,
    input  wr_data_b,
    input  busy,
    input  done
  );

endinterface

// File: rtl/twiddle_load_sequencer.sv
// One-shot twiddle table preload: ROM pair fetch,
// latency realignment and bank write sequencing.
module twiddle_load_sequencer #(
  parameter int DEPTH   = 128,
  parameter int AW      = 7,
  parameter int DW      = 16,
  parameter int ROM_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  twiddle_load_sequencer_if.slave bus
);

  localparam int KW = AW - 1;

  localparam logic [KW-1:0] K_LAST =
    KW'(DEPTH / 2 - 1);
  localparam logic [2:0] DRAIN_INIT =
    3'(ROM_LAT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [KW-1:0]      k_q;
  logic [KW-1:0]      k_d;
  logic               b_lsb_q;
  logic               b_lsb_d;
  logic               loaded_q;
  logic               loaded_d;
  logic [2:0]         drain_q;
  logic [2:0]         drain_d;
  logic [ROM_LAT-1:0] pv_q;
  logic [ROM_LAT-1:0] pv_d;
  logic [KW-1:0]      pk_q [ROM_LAT];

  logic is_idle;
  logic is_fetch;
  logic is_drain;
  logic is_done;
  logic cancel;

  assign is_idle  = (state_q == S_IDLE);
  assign is_fetch = (state_q == S_FETCH);
  assign is_drain = (state_q == S_DRAIN);
  assign is_done  = (state_q == S_DONE);
  assign cancel   = bus.abort
                  & (is_fetch | is_drain);

  // Next-state, pair counter and loaded flag.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    b_lsb_d  = b_lsb_q;
    loaded_d = loaded_q;
    drain_d  = drain_q;
    unique case (1'b1)
      is_idle: begin
        if (bus.start && !bus.abort) begin
          state_d  = S_FETCH;
          k_d      = '0;
          b_lsb_d  = 1'b1;
          loaded_d = 1'b0;
        end
      end
      is_fetch: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      is_drain: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (drain_q == 3'd0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end
      is_done: begin
        state_d  = S_IDLE;
        loaded_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Delay pipe valid bits; abort flushes them.
  always_comb begin
    pv_d    = '0;
    pv_d[0] = is_fetch & ~cancel;
    for (int i = 1; i < ROM_LAT; i++) begin
      pv_d[i] = pv_q[i-1] & ~cancel;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      b_lsb_q  <= 1'b0;
      loaded_q <= 1'b0;
      drain_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      b_lsb_q  <= b_lsb_d;
      loaded_q <= loaded_d;
      drain_q  <= drain_d;
    end
  end

  // Pair index follows the ROM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        pk_q[i] <= '0;
      end
    end else begin
      pv_q    <= pv_d;
      pk_q[0] <= k_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        pk_q[i] <= pk_q[i-1];
      end
    end
  end

  // Port B low bit stays 0 until a load has
  // begun, so both addresses reset to zero.
  assign bus.addr_a    = {loaded_q, k_q, 1'b0};
  assign bus.addr_b    = {loaded_q, k_q, b_lsb_q};

  assign bus.wr_en     = pv_q[ROM_LAT-1];
  assign bus.wr_addr_a = {pk_q[ROM_LAT-1], 1'b0};
  assign bus.wr_addr_b = {pk_q[ROM_LAT-1],
                          pv_q[ROM_LAT-1]};
  assign bus.wr_data_a = bus.rom_q_a;
  assign bus.wr_data_b = bus.rom_q_b;

  assign bus.busy      = is_fetch | is_drain;
  assign bus.done      = is_done;

endmodule

// File: tb/tb_twiddle_load_sequencer.sv
// Randomised bench for the twiddle preload
// sequencer over three DEPTH/ROM_LAT configurations.
module tb_twiddle_load_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  function automatic string tg(
    input int g, input string s);
    return $sformatf("g%0d.%s", g, s);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int D  = (g == 2) ? 16 : 128;
    localparam int L  = (g == 0) ? 1 :
                        (g == 1) ? 2 : 4;
    localparam int AW = $clog2(D);
    localparam int P  = D / 2;

    logic rst_n = 1'b1;
    bit   fin   = 1'b0;

    twiddle_load_sequencer_if #(
      .AW(AW), .DW(16)
    ) bus ();

    twiddle_load_sequencer #(
      .DEPTH(D), .AW(AW),
      .DW(16), .ROM_LAT(L)
    ) dut (
      .clk(clk),
      .reset_n(rst_n),
      .bus(bus)
    );

    // ROM: q = address * 3 after L clocks
    logic [AW-1:0] ra [L];
    logic [AW-1:0] rb [L];
    always @(posedge clk) begin
      ra[0] <= bus.addr_a[AW-1:0];
      rb[0] <= bus.addr_b[AW-1:0];
      for (int i = 1; i < L; i++) begin
        ra[i] <= ra[i-1];
        rb[i] <= rb[i-1];
      end
    end
    assign bus.rom_q_a = 16'(ra[L-1]) * 16'd3;
    assign bus.rom_q_b = 16'(rb[L-1]) * 16'd3;

    // Reference: a load is the edge number
    // it was accepted on; everything else is
    // an offset from that edge.
    int n      = 0;
    int ld     = -1;
    int lastp  = 0;
    bit loaded = 1'b0;
    bit anyl   = 1'b0;

    always @(posedge clk) begin
      n++;
      if (!rst_n) begin
        ld     = -1;
        lastp  = 0;
        loaded = 1'b0;
        anyl   = 1'b0;
      end else begin
        if (ld >= 0) begin
          if (n - 1 - ld == P + L) begin
            loaded = 1'b1;
            ld     = -1;
          end else if (bus.abort) begin
            ld = -1;
          end
        end else if (bus.start && !bus.abort) begin
          ld     = n;
          loaded = 1'b0;
          anyl   = 1'b1;
        end
        if (ld >= 0 && n - ld < P) lastp = n - ld;
      end
    end

    logic [15:0] bank [D];
    int          wcnt [D];
    int          nwr   = 0;
    int          ndone = 0;

    always @(negedge clk) begin
      int off;
      int j;
      bit ew;
      if (!rst_n) begin
        check(tg(g, "rst.busy"), bus.busy, 0);
        check(tg(g, "rst.done"), bus.done, 0);
        check(tg(g, "rst.wr_en"), bus.wr_en, 0);
        check(tg(g, "rst.addr_a"), bus.addr_a, 0);
        check(tg(g, "rst.addr_b"), bus.addr_b, 0);
        check(tg(g, "rst.wr_addr_a"),
              bus.wr_addr_a, 0);
        check(tg(g, "rst.wr_addr_b"),
              bus.wr_addr_b, 0);
      end else begin
        off = n - ld;
        ew  = (ld >= 0) && off >= L && off < P + L;
        check(tg(g, "busy"), bus.busy,
              64'((ld >= 0) && off < P + L));
        check(tg(g, "done"), bus.done,
              64'((ld >= 0) && off == P + L));
        check(tg(g, "wr_en"), bus.wr_en, 64'(ew));
        check(tg(g, "addr_a"), bus.addr_a,
              64'(int'(loaded) * D + 2 * lastp));
        check(tg(g, "addr_b"), bus.addr_b,
              64'(int'(loaded) * D + 2 * lastp
                  + int'(anyl)));
        if (ew) begin
          j = off - L;
          check(tg(g, "wr_addr_a"),
                bus.wr_addr_a, 64'(2 * j));
          check(tg(g, "wr_addr_b"),
                bus.wr_addr_b, 64'(2 * j + 1));
          check(tg(g, "wr_data_a"),
                bus.wr_data_a, 64'(6 * j));
          check(tg(g, "wr_data_b"),
                bus.wr_data_b, 64'(6 * j + 3));
        end
        if (bus.wr_en) begin
          bank[bus.wr_addr_a] = bus.wr_data_a;
          bank[bus.wr_addr_b] = bus.wr_data_b;
          wcnt[bus.wr_addr_a]++;
          wcnt[bus.wr_addr_b]++;
          nwr++;
        end
        if (bus.done) ndone++;
      end
    end

    // Loads: 0 plain, 1 extra starts,
    // 2 abort, 3 reset mid-load, 4 abort in DONE
    initial begin
      int ab_at;
      int rs_at;
      bit cut;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int mode = 0; mode < 5; mode++) begin
        repeat ($urandom_range(4, 1)) @(negedge clk);
        for (int i = 0; i < D; i++) begin
          bank[i] = '0;
          wcnt[i] = 0;
        end
        nwr   = 0;
        ndone = 0;
        ab_at = (g == 1) ? 20 :
                int'($urandom_range(P + L - 1, 0));
        rs_at = (g == 0) ? 30 :
                int'($urandom_range(P + L - 1, 0));
        if (mode == 2) begin
          bus.start = 1'b1;
          bus.abort = 1'b1;
          repeat (2) @(negedge clk);
          bus.abort = 1'b0;
        end
        bus.start = 1'b1;
        @(negedge clk);
        cut = 1'b0;
        for (int m = 0; m <= P + L + 1 && !cut; m++) begin
          bus.start = (mode == 1) &&
            (m == 10 || m == P + L ||
             (m < P + L && $urandom_range(3, 0) == 0));
          bus.abort =
            (mode == 2 && m == ab_at) ||
            (mode == 4 && m == P + L);
          if (mode == 3 && m == rs_at) begin
            #2 rst_n = 1'b0;
            #1;
            check(tg(g, "async.busy"), bus.busy, 0);
            check(tg(g, "async.wr_en"), bus.wr_en, 0);
            check(tg(g, "async.addr_a"),
                  bus.addr_a, 0);
            check(tg(g, "async.addr_b"),
                  bus.addr_b, 0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            cut   = 1'b1;
          end else begin
            @(negedge clk);
          end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (L + 3) @(negedge clk);
        if (mode == 2) begin
          check(tg(g, "abort.ndone"), ndone, 0);
          check(tg(g, "abort.nwr"), nwr,
                64'((ab_at >= L) ? ab_at - L + 1 : 0));
          check(tg(g, "abort.loaded"),
                bus.addr_a[AW], 0);
        end else if (mode == 3) begin
          check(tg(g, "reset.ndone"), ndone, 0);
        end else begin
          check(tg(g, "load.nwr"), nwr, P);
          check(tg(g, "load.ndone"), ndone, 1);
          check(tg(g, "load.loaded"),
                bus.addr_a[AW], 1);
          for (int i = 0; i < D; i++) begin
            check(tg(g, "image"), bank[i], 3 * i);
            check(tg(g, "wcnt"), wcnt[i], 1);
          end
        end
      end
      fin = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 5000; c++) begin
      if (gi[0].fin && gi[1].fin && gi[2].fin)
        break;
      @(negedge clk);
    end
    if (!(gi[0].fin && gi[1].fin && gi[2].fin))
      check("timeout",
            {gi[0].fin, gi[1].fin, gi[2].fin},
            3'b111);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
